// File: rtl/slice_unpack_pkg.sv
// slice_unpack_pkg: shared FSM state type and default geometry for slice_unpacker.
package slice_unpack_pkg;
    typedef enum logic {IDLE, EMIT} state_t;
    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;
endpackage

// File: rtl/slice_unpack_ctr.sv
// slice_unpack_ctr: slice index counter with clear, increment-enable and last-slice flag.
module slice_unpack_ctr #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] idx,
    output logic          is_last
);
    always_ff @(posedge clk)
        idx <= (rst || clr) ? '0 : inc ? idx + IW'(1) : idx;
    assign is_last = idx == IW'(N - 1);
endmodule

// File: rtl/slice_unpacker.sv
// slice_unpacker: splits WIDTH-bit words into N=WIDTH/SLICE slices, LSB slice first.
// Define UNPACK_MSB_FIRST_EN to emit the MSB slice first instead.
module slice_unpacker
    import slice_unpack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SLICE-1:0] out_data,
    output logic             out_last
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = $clog2(N);

    if (WIDTH % SLICE != 0 || WIDTH / SLICE < 2) begin : g_bad_params
        $error("slice_unpacker: WIDTH must be a multiple of SLICE with at least two slices");
    end

    state_t                    state, state_nx;
    logic [N-1:0][SLICE-1:0]   held;
    logic [IW-1:0]             idx, sel;
    logic                      is_last, in_hs, out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    slice_unpack_ctr #(.N(N), .IW(IW)) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (in_hs),
        .inc     (out_hs && !is_last),
        .idx     (idx),
        .is_last (is_last)
    );

    // An accept always lands in EMIT; in EMIT it can only coincide with the last out handshake.
    always_comb
        state_nx = in_hs ? EMIT : (out_hs && is_last) ? IDLE : state;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
        held  <= rst ? '0 : in_hs ? in_data : held;
    end

`ifdef UNPACK_MSB_FIRST_EN
    assign sel = IW'(N - 1) - idx;
`else
    assign sel = idx;
`endif

    assign out_valid = state == EMIT;
    assign out_last  = out_valid && is_last;
    assign out_data  = held[sel];
    assign in_ready  = (state == IDLE) || (is_last && out_ready);
endmodule

// File: tb/tb_slice_unpacker.sv
// tb_slice_unpacker: directed and randomized checks of slice_unpacker against a slice-queue model.
module tb_slice_unpacker;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, out_last;
    logic [3:0]  out_data;
    int          checks = 0, failures = 0;
    logic [3:0]  q[$];

    slice_unpacker #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending slices of the word in flight, front = slice on the output.
    task automatic cycle(input logic iv, input logic [15:0] id, input logic ordy, input logic r);
        logic rdy_exp;
        in_valid = iv; in_data = id; out_ready = ordy; rst = r;
        #1;
        rdy_exp = q.size() == 0 || (q.size() == 1 && ordy);
        check("in_ready", in_ready, rdy_exp);
        check("out_valid", out_valid, q.size() != 0);
        check("out_last", out_last, q.size() == 1);
        if (q.size() != 0) check("out_data", out_data, q[0]);
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (iv && rdy_exp)
                for (int k = 0; k < 4; k++)
`ifdef UNPACK_MSB_FIRST_EN
                    q.push_back(id[(3 - k) * 4 +: 4]);
`else
                    q.push_back(id[k * 4 +: 4]);
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        // single word
        cycle(1, 16'hA5C3, 1, 0);
        repeat (5) cycle(0, 16'h0, 1, 0);
        // back-to-back with in_valid held high
        cycle(1, 16'h1234, 1, 0);
        repeat (4) cycle(1, 16'hABCD, 1, 0);
        repeat (5) cycle(0, 16'h0, 1, 0);
        // backpressure on slice C
        cycle(1, 16'hA5C3, 1, 0);
        cycle(0, 16'h0, 1, 0);
        repeat (3) cycle(0, 16'h0, 0, 0);
        repeat (4) cycle(0, 16'h0, 1, 0);
        // reset mid-word, with a concurrent offered word that must be ignored
        cycle(1, 16'hA5C3, 1, 0);
        repeat (2) cycle(0, 16'h0, 1, 0);
        cycle(1, 16'hFFFF, 1, 1);
        cycle(1, 16'h0F0F, 1, 0);
        repeat (5) cycle(0, 16'h0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 60) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
